// File: rtl/cpu_run_ctrl_if.sv
// ============================================================================
// Module      : cpu_run_ctrl_if
// Description : Host command port for the run controller (valid/ready + read-back).
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface cpu_run_ctrl_if;
    logic        host_valid;
    logic        host_ready;
    logic [1:0]  host_cmd;
    logic [7:0]  host_addr;
    logic [15:0] host_wdata;
    logic [15:0] host_rdata;
    logic        host_rvalid;

    modport master (
        output host_valid, host_cmd, host_addr, host_wdata,
        input  host_ready, host_rdata, host_rvalid
    );

    modport slave (
        input  host_valid, host_cmd, host_addr, host_wdata,
        output host_ready, host_rdata, host_rvalid
    );
endinterface

`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
// ============================================================================
// Module      : cpu_run_ctrl
// Description : Loads, starts, watches and stops the CPU core; muxes its memories.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module cpu_run_ctrl #(
    parameter int MAX_CYCLES  = 16'hFFFF,
    parameter int HALT_STABLE = 4,
    parameter int RST_CYCLES  = 2
) (
    input  wire logic        clock,
    input  wire logic        reset,
    cpu_run_ctrl_if.slave    host,
    output logic             done,
    output logic             timeout,
    output logic [15:0]      cycle_count,
    output logic             cpu_rst_n,
    output logic             cpu_enable,
    output logic             cpu_start,
    input  wire logic [7:0]  cpu_i_addr,
    input  wire logic        cpu_d_we,
    input  wire logic [7:0]  cpu_d_addr,
    input  wire logic [15:0] cpu_d_dataout,
    output logic             imem_we,
    output logic [7:0]       imem_addr,
    output logic [15:0]      imem_wdata,
    output logic             dmem_we,
    output logic [7:0]       dmem_addr,
    output logic [15:0]      dmem_wdata,
    input  wire logic [15:0] dmem_rdata
);

    localparam int              c_STW        = $clog2(HALT_STABLE + 1);
    localparam int              c_RSTW       = $clog2(RST_CYCLES + 1);
    localparam logic [c_STW-1:0]  c_STABLE_LAST = c_STW'(HALT_STABLE - 1);
    localparam logic [c_RSTW-1:0] c_RST_LAST    = c_RSTW'(RST_CYCLES - 1);
    localparam logic [15:0]     c_CYC_LAST   = 16'(MAX_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CRST  = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [c_RSTW-1:0] r_rst_cnt;
    logic [c_STW-1:0]  r_stable;
    logic [7:0]        r_prev_iaddr;
    logic [15:0]       r_rdata;
    logic              r_rvalid;
    logic              r_done;
    logic              r_timeout;
    logic [15:0]       r_cycle;

    logic w_host_side;
    logic w_accept;
    logic w_in_run;
    logic w_addr_eq;
    logic w_halt;
    logic w_tmo;

    assign w_host_side = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_accept    = host.host_valid && w_host_side;
    assign w_in_run    = (r_state == S_RUN);
    assign w_addr_eq   = (cpu_i_addr == r_prev_iaddr);
    assign w_halt      = w_in_run && w_addr_eq && (r_stable == c_STABLE_LAST);
    assign w_tmo       = w_in_run && (r_cycle == c_CYC_LAST);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (w_accept && host.host_cmd == 2'b11) w_state_next = S_CRST;
            S_CRST:         if (r_rst_cnt == c_RST_LAST) w_state_next = S_START;
            S_START:        w_state_next = S_RUN;
            S_RUN:          if (w_halt || w_tmo) w_state_next = S_DONE;
            default:        w_state_next = S_IDLE;
        endcase
    end

    // Core controls are pure state decodes so an async reset drops them at once.
    always_comb begin
        host.host_ready = w_host_side;
        cpu_rst_n       = (r_state == S_START) || w_in_run;
        cpu_enable      = (r_state == S_START) || w_in_run;
        cpu_start       = (r_state == S_START);
        imem_we         = w_accept && (host.host_cmd == 2'b00);
        imem_addr       = w_in_run ? cpu_i_addr : host.host_addr;
        imem_wdata      = host.host_wdata;
        dmem_we         = w_in_run ? cpu_d_we : (w_accept && (host.host_cmd == 2'b01));
        dmem_addr       = w_in_run ? cpu_d_addr : host.host_addr;
        dmem_wdata      = w_in_run ? cpu_d_dataout : host.host_wdata;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_rst_cnt    <= '0;
            r_stable     <= '0;
            r_prev_iaddr <= '0;
            r_rdata      <= '0;
            r_rvalid     <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
            r_cycle      <= '0;
        end else begin
            r_state      <= w_state_next;
            r_prev_iaddr <= cpu_i_addr;
            r_rst_cnt    <= (r_state == S_CRST) ? r_rst_cnt + c_RSTW'(1) : '0;
            r_stable     <= (w_in_run && w_addr_eq) ? r_stable + c_STW'(1) : '0;
            r_rvalid     <= w_accept && (host.host_cmd == 2'b10);
            if (w_accept && host.host_cmd == 2'b10) r_rdata <= dmem_rdata;
            if (w_accept && host.host_cmd == 2'b11) begin
                r_done    <= 1'b0;
                r_timeout <= 1'b0;
                r_cycle   <= '0;
            end
            if (w_in_run) begin
                if (r_cycle != 16'hFFFF) r_cycle <= r_cycle + 16'd1;
                // Halt wins over timeout when both land on the same clock.
                if (w_halt || w_tmo) begin
                    r_done    <= 1'b1;
                    r_timeout <= !w_halt;
                end
            end
        end
    end

    assign host.host_rdata  = r_rdata;
    assign host.host_rvalid = r_rvalid;
    assign done             = r_done;
    assign timeout          = r_timeout;
    assign cycle_count      = r_cycle;

endmodule

`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
// ============================================================================
// Module      : tb_cpu_run_ctrl
// Description : Directed + randomized bench for cpu_run_ctrl with a fake core.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_cpu_run_ctrl;
    localparam int MAXC  = 20;
    localparam int HSTAB = 4;
    localparam int RSTC  = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        done, timeout;
    logic [15:0] cycle_count;
    logic        cpu_rst_n, cpu_enable, cpu_start;
    logic [7:0]  cpu_i_addr, cpu_d_addr;
    logic        cpu_d_we;
    logic [15:0] cpu_d_dataout;
    logic        imem_we, dmem_we;
    logic [7:0]  imem_addr, dmem_addr;
    logic [15:0] imem_wdata, dmem_wdata, dmem_rdata;

    cpu_run_ctrl_if hif ();

    cpu_run_ctrl #(.MAX_CYCLES(MAXC), .HALT_STABLE(HSTAB), .RST_CYCLES(RSTC)) dut (
        .clock(clock), .reset(reset), .host(hif.slave),
        .done(done), .timeout(timeout), .cycle_count(cycle_count),
        .cpu_rst_n(cpu_rst_n), .cpu_enable(cpu_enable), .cpu_start(cpu_start),
        .cpu_i_addr(cpu_i_addr), .cpu_d_we(cpu_d_we), .cpu_d_addr(cpu_d_addr),
        .cpu_d_dataout(cpu_d_dataout),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata)
    );

    always #5 clock = ~clock;

    // Memories and a scripted stand-in core.
    logic [15:0] imem_m [256] = '{default: 16'h0000};
    logic [15:0] dmem_m [256] = '{default: 16'h0000};
    logic [15:0] ref_imem [256] = '{default: 16'h0000};
    logic [15:0] ref_dmem [256] = '{default: 16'h0000};
    logic [7:0]  trace [64];
    logic [5:0]  run_k = '0;
    int          start_cnt = 0;
    logic [7:0]  st_addr = 8'h00;
    logic [15:0] st_data = 16'h0000;
    logic        in_run;

    always @(posedge clock) begin
        if (imem_we) imem_m[imem_addr] <= imem_wdata;
        if (dmem_we) dmem_m[dmem_addr] <= dmem_wdata;
        if (cpu_start) start_cnt <= start_cnt + 1;
        if (cpu_start) run_k <= '0;
        else if (in_run) run_k <= run_k + 6'd1;
    end

    assign dmem_rdata    = dmem_m[dmem_addr];
    assign in_run        = cpu_enable && !cpu_start;
    assign cpu_i_addr    = in_run ? trace[run_k] : 8'h00;
    assign cpu_d_we      = in_run ? (run_k == 6'd1) : 1'b1;
    assign cpu_d_addr    = in_run ? st_addr : 8'hFF;
    assign cpu_d_dataout = in_run ? st_data : 16'hDEAD;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Run length/outcome straight from the rules: count equal-address streaks.
    function automatic void predict(output int len, output bit tmo);
        int         s = 0;
        logic [7:0] prev = 8'h00;
        len = MAXC;
        tmo = 1'b1;
        for (int j = 0; j < MAXC; j++) begin
            if (trace[j] == prev) s++; else s = 0;
            prev = trace[j];
            if (s >= HSTAB) begin
                len = j + 1;
                tmo = 1'b0;
                return;
            end
        end
    endfunction

    task automatic gen_trace(input int kind);
        int         k;
        int         hold = 0;
        logic [7:0] a;
        k = $urandom_range(1, MAXC);
        if (kind == 3) k = MAXC - HSTAB;
        a = 8'($urandom);
        for (int j = 0; j < 64; j++) begin
            case (kind)
                0, 3: trace[j] = (j < k) ? 8'(j + 1) : 8'(k);
                1: begin
                    if (j > 0 && hold < HSTAB - 1 && $urandom_range(0, 1) == 1) hold++;
                    else begin
                        a    = a + 8'd1;
                        hold = 0;
                    end
                    trace[j] = a;
                end
                default: trace[j] = a + 8'(j & 1);
            endcase
        end
        st_addr = 8'($urandom_range(0, 254));
        st_data = 16'($urandom);
    endtask

    task automatic host_issue(input logic [1:0] cmd, input logic [7:0] addr, input logic [15:0] wd);
        bit ok = 1'b0;
        @(negedge clock);
        hif.host_valid = 1'b1;
        hif.host_cmd   = cmd;
        hif.host_addr  = addr;
        hif.host_wdata = wd;
        for (int n = 0; n < 200; n++) begin
            if (hif.host_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        chk("accept_bound", ok, 1);
        @(posedge clock);
        #1;
        hif.host_valid = 1'b0;
    endtask

    task automatic host_wr_imem(input logic [7:0] addr, input logic [15:0] d);
        host_issue(2'b00, addr, d);
        ref_imem[addr] = d;
    endtask

    task automatic host_wr_dmem(input logic [7:0] addr, input logic [15:0] d);
        host_issue(2'b01, addr, d);
        ref_dmem[addr] = d;
    endtask

    task automatic host_rd(input string tag, input logic [7:0] addr);
        host_issue(2'b10, addr, 16'h0000);
        chk({tag, "_rvalid"}, hif.host_rvalid, 1);
        chk({tag, "_rdata"}, hif.host_rdata, ref_dmem[addr]);
        @(posedge clock);
        #1;
        chk({tag, "_rvalid_drop"}, hif.host_rvalid, 0);
    endtask

    task automatic do_run(input string tag, input bit pend, input bit mid_reset);
        int          exp_len;
        bit          exp_to;
        int          starts0;
        int          crst = 0;
        int          w = 0;
        int          viol = 0;
        logic [15:0] pend_d;
        logic [15:0] pend_old;
        predict(exp_len, exp_to);
        starts0 = start_cnt;
        host_issue(2'b11, 8'h00, 16'h0000);
        chk({tag, "_clr_done"}, done, 0);
        chk({tag, "_clr_timeout"}, timeout, 0);
        chk({tag, "_clr_cycles"}, cycle_count, 0);
        chk({tag, "_ready_low"}, hif.host_ready, 0);
        pend_d   = 16'($urandom);
        pend_old = imem_m[8'hC0];
        if (pend) begin
            hif.host_valid = 1'b1;
            hif.host_cmd   = 2'b00;
            hif.host_addr  = 8'hC0;
            hif.host_wdata = pend_d;
        end
        for (int n = 0; n < 10; n++) begin
            @(negedge clock);
            if (cpu_start) break;
            crst++;
        end
        chk({tag, "_crst_len"}, crst, RSTC);
        chk({tag, "_start_rstn"}, cpu_rst_n, 1);
        chk({tag, "_start_en"}, cpu_enable, 1);
        if (mid_reset) begin
            repeat (3) @(negedge clock);
            reset = 1'b0;
            #1;
            chk({tag, "_ar_en"}, cpu_enable, 0);
            chk({tag, "_ar_rstn"}, cpu_rst_n, 0);
            chk({tag, "_ar_done"}, done, 0);
            chk({tag, "_ar_ready"}, hif.host_ready, 1);
            chk({tag, "_ar_cycles"}, cycle_count, 0);
            ref_dmem[st_addr] = st_data;
            @(negedge clock);
            reset = 1'b1;
            return;
        end
        while (!done && w < 200) begin
            @(negedge clock);
            w++;
            if (!done && (hif.host_ready || imem_we)) viol++;
        end
        ref_dmem[st_addr] = st_data;
        chk({tag, "_host_blocked"}, viol, 0);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_timeout"}, timeout, exp_to);
        chk({tag, "_cycles"}, cycle_count, exp_len);
        chk({tag, "_en_off"}, cpu_enable, 0);
        chk({tag, "_rstn_off"}, cpu_rst_n, 0);
        chk({tag, "_ready_back"}, hif.host_ready, 1);
        chk({tag, "_one_start"}, start_cnt - starts0, 1);
        if (pend) begin
            chk({tag, "_pend_unwritten"}, imem_m[8'hC0], pend_old);
            @(posedge clock);
            #1;
            hif.host_valid = 1'b0;
            ref_imem[8'hC0] = pend_d;
            @(negedge clock);
            chk({tag, "_pend_written"}, imem_m[8'hC0], ref_imem[8'hC0]);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        hif.host_valid = 1'b0;
        hif.host_cmd   = 2'b00;
        hif.host_addr  = 8'h00;
        hif.host_wdata = 16'h0000;
        for (int j = 0; j < 64; j++) trace[j] = 8'h00;
        repeat (3) @(negedge clock);
        chk("rst_ready", hif.host_ready, 1);
        chk("rst_rvalid", hif.host_rvalid, 0);
        chk("rst_rdata", hif.host_rdata, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_cycles", cycle_count, 0);
        chk("rst_rstn", cpu_rst_n, 0);
        chk("rst_en", cpu_enable, 0);
        chk("rst_start", cpu_start, 0);
        reset = 1'b1;

        host_wr_imem(8'd0, 16'h1105);
        host_wr_imem(8'd1, 16'h1103);
        host_wr_imem(8'd2, 16'h5108);
        host_wr_imem(8'd3, 16'hF000);
        @(negedge clock);
        for (int i = 0; i < 4; i++) chk("imem_load", imem_m[i], ref_imem[i]);
        for (int j = 0; j < 64; j++) trace[j] = (j < 4) ? 8'(j + 1) : 8'd4;
        st_addr = 8'd8;
        st_data = 16'h0008;
        do_run("halt_prog", 1'b0, 1'b0);
        host_rd("rd_d8", 8'd8);

        gen_trace(2);
        do_run("jump_self", 1'b0, 1'b0);
        host_rd("rd_jump", st_addr);

        gen_trace(0);
        do_run("pending", 1'b1, 1'b0);

        host_wr_dmem(8'd3, 16'hBEEF);
        host_rd("rd_beef", 8'd3);

        gen_trace(1);
        do_run("midreset", 1'b0, 1'b1);
        gen_trace(0);
        do_run("after_reset", 1'b0, 1'b0);
        host_rd("rd_after_reset", st_addr);

        gen_trace(3);
        do_run("coincide", 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            gen_trace($urandom_range(0, 2));
            do_run("b2b", 1'b0, 1'b0);
            host_rd("rd_b2b", st_addr);
        end

        @(negedge clock);
        chk("dmem_ff_untouched", dmem_m[8'hFF], ref_dmem[8'hFF]);
        chk("imem_kept", imem_m[2], ref_imem[2]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Host-facing run controller for the 16-bit 5-stage CPU core and its 256x16 instruction and data memories.
- Loads a program and data image over a valid/ready command port, then resets and starts the core.
- While the core runs, it detects halt or a cycle-budget timeout, stops the core, and gives the host read-back access to data memory.
- Owns the memory address/write muxes between the host and the core.

Parameters:
- MAX_CYCLES, 16'hFFFF, run budget in clocks; reaching it ends the run with timeout.
- HALT_STABLE, 4, consecutive cycles cpu_i_addr must stay unchanged in RUN to declare halt.
- RST_CYCLES, 2, clocks cpu_rst_n is held low before start.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low
- host_valid  in  1  command valid
- host_ready  out  1  command accepted when valid&ready
- host_cmd  in  2  00 write imem, 01 write dmem, 10 read dmem, 11 run
- host_addr  in  8  memory address
- host_wdata  in  16  write data
- host_rdata  out  16  read data
- host_rvalid  out  1  one-cycle pulse, host_rdata valid
- done  out  1  run finished (level)
- timeout  out  1  last run hit MAX_CYCLES
- cycle_count  out  16  clocks spent in RUN for the last run
- cpu_rst_n  out  1  core reset, active-low
- cpu_enable  out  1  core enable
- cpu_start  out  1  core start
- cpu_i_addr  in  8  core fetch address
- cpu_d_we  in  1  core data write enable
- cpu_d_addr  in  8  core data address
- cpu_d_dataout  in  16  core store data
- imem_we  out  1  instruction memory write
- imem_addr  out  8  instruction memory address
- imem_wdata  out  16  instruction memory write data
- dmem_we  out  1  data memory write
- dmem_addr  out  8  data memory address
- dmem_wdata  out  16  data memory write data
- dmem_rdata  in  16  data memory combinational read data

Behaviour:
- Reset values: state IDLE; host_ready 1; host_rvalid 0; host_rdata 0; done 0; timeout 0; cycle_count 0; cpu_rst_n 0; cpu_enable 0; cpu_start 0.
- States are IDLE, CRST, START, RUN, DONE.
- IDLE/DONE:
  - host_ready=1 and memories are owned by the host.
  - imem_we = valid&ready&cmd==00, combinational; same-cycle write with imem_addr=host_addr, imem_wdata=host_wdata.
  - dmem_we = valid&ready&cmd==01; dmem_addr=host_addr, dmem_wdata=host_wdata.
  - cmd 10: host_rdata <= dmem_rdata at host_addr, registered; host_rvalid pulses the next cycle, latency 1.
  - cmd 11: go to CRST. Clear done, timeout and cycle_count, and deassert host_ready from the next cycle.
  - cpu_rst_n stays 0 in IDLE and DONE so the core is frozen.
- CRST: cpu_rst_n=0 for RST_CYCLES clocks, then go to START with cpu_rst_n=1.
- START:
  - One clock with cpu_enable=1 and cpu_start=1, then go to RUN.
  - cpu_start is 0 in every other state.
- RUN:
  - cpu_enable=1; host_ready=0; memory muxes select the core.
  - imem_addr=cpu_i_addr; dmem_addr=cpu_d_addr; dmem_we=cpu_d_we; dmem_wdata=cpu_d_dataout.
  - cycle_count increments each RUN clock and saturates at 16'hFFFF.
  - Halt detect: a stable counter increments when cpu_i_addr equals its previous-cycle value and clears otherwise. Reaching HALT_STABLE goes to DONE with timeout=0. A jump-to-self loop is also treated as halt.
  - Timeout: cycle_count==MAX_CYCLES-1 on a RUN clock goes to DONE with timeout=1. Halt has priority if both occur on the same clock.
- DONE entry: cpu_enable<=0, cpu_rst_n<=0, done<=1. done is held until the next run command.
- host_valid in CRST/START/RUN is not accepted; the host must hold it until host_ready.
- Asynchronous reset mid-run returns to IDLE immediately with all outputs at reset values. Memory contents are not touched.

Test Plan:
- Reset, write imem[0..3]={ADDI gr1 5, ADDI gr1 3, STORE gr1->d[8], HALT} via cmd 00, run (cmd 11) -> CRST 2 clocks, a single cpu_start pulse, done=1, timeout=0, then cmd 10 addr 8 -> host_rvalid one cycle later with host_rdata=0x0008.
- Program JUMP to self with MAX_CYCLES=20, HALT_STABLE=64 -> done=1, timeout=1, cycle_count=20, cpu_enable=0.
- Commands with host_valid=1 during RUN -> host_ready=0, no imem/dmem writes from the host, and the command is accepted only after done.
- cmd 01 write dmem[3]=0xBEEF, then cmd 10 addr 3 -> host_rdata=0xBEEF, with host_rvalid high exactly 1 cycle.
- Assert reset in the middle of RUN -> cpu_enable=0, cpu_rst_n=0, done=0, host_ready=1 asynchronously; a subsequent run behaves normally.
- Two back-to-back runs -> cycle_count and timeout are cleared at the second cmd 11, and done drops until the second halt.
